// File: rtl/tx_link_sequencer.sv
// Link bring-up bit source: alternating preamble, PRBS7 training, then payload.
// Ports: clk, rst_n, start/stop control, data_in/data_valid/data_ready payload,
// bit_out/tx_en to the TX driver, state and underflow_cnt for observation.
module tx_link_sequencer #(
  parameter int PREAMBLE_LEN = 32,
  parameter int TRAIN_LEN    = 127,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             bit_out,
  output logic             tx_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] underflow_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRE   = 2'd1;
  localparam logic [1:0] S_TRAIN = 2'd2;
  localparam logic [1:0] S_DATA  = 2'd3;

  localparam logic [6:0] SEED    = 7'h7F;
  localparam logic       SEED_FB = SEED[6] ^ SEED[5];

  localparam logic [CNT_W-1:0] PRE_END   = CNT_W'(PREAMBLE_LEN);
  localparam logic [CNT_W-1:0] TRAIN_END = CNT_W'(TRAIN_LEN);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic             bit_q, bit_d;
  logic             tx_en_q, tx_en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       lfsr_q, lfsr_d;
  logic [CNT_W-1:0] uf_q, uf_d;
  logic             fb;

  assign fb            = lfsr_q[6] ^ lfsr_q[5];
  assign data_ready    = (state_q == S_DATA) && !stop;
  assign bit_out       = bit_q;
  assign tx_en         = tx_en_q;
  assign state         = state_q;
  assign underflow_cnt = uf_q;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    tx_en_d = tx_en_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    uf_d    = uf_q;
    if (stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      bit_d   = 1'b0;
      tx_en_d = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          bit_d   = 1'b0;
          tx_en_d = 1'b0;
          if (start && !stop) begin
            state_d = S_PRE;
            bit_d   = 1'b1;
            tx_en_d = 1'b1;
            cnt_d   = ONE;
            uf_d    = '0;
          end
        end
        S_PRE: begin
          if (cnt_q == PRE_END) begin
            // entry edge already emits the first PRBS bit from the seed
            state_d = S_TRAIN;
            bit_d   = SEED_FB;
            lfsr_d  = {SEED[5:0], SEED_FB};
            cnt_d   = ONE;
          end else begin
            bit_d = ~bit_q;
            cnt_d = cnt_q + ONE;
          end
        end
        S_TRAIN: begin
          if (cnt_q == TRAIN_END) begin
            state_d = S_DATA;
            bit_d   = 1'b0;
            cnt_d   = '0;
          end else begin
            bit_d  = fb;
            lfsr_d = {lfsr_q[5:0], fb};
            cnt_d  = cnt_q + ONE;
          end
        end
        S_DATA: begin
          if (data_valid) begin
            bit_d = data_in;
          end else begin
            bit_d = 1'b0;
            if (!(&uf_q)) uf_d = uf_q + ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bit_q   <= 1'b0;
      tx_en_q <= 1'b0;
      cnt_q   <= '0;
      lfsr_q  <= SEED;
      uf_q    <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      tx_en_q <= tx_en_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      uf_q    <= uf_d;
    end
  end

endmodule

// File: tb/tb_tx_link_sequencer.sv
// Scoreboard bench for tx_link_sequencer: two instances (default and small)
// driven together, each checked against an index-based sequence model.
module tb_tx_link_sequencer;

  localparam int P0 = 32;
  localparam int T0 = 127;
  localparam int P1 = 4;
  localparam int T1 = 7;

  logic clk, rst_n, start, stop, data_in, data_valid;
  logic dr0, bo0, te0, dr1, bo1, te1;
  logic [1:0] st0, st1;
  logic [15:0] uf0;
  logic [2:0] uf1;

  tx_link_sequencer #(.PREAMBLE_LEN(P0), .TRAIN_LEN(T0), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .data_in(data_in), .data_valid(data_valid), .data_ready(dr0),
    .bit_out(bo0), .tx_en(te0), .state(st0), .underflow_cnt(uf0)
  );

  tx_link_sequencer #(.PREAMBLE_LEN(P1), .TRAIN_LEN(T1), .CNT_W(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .data_in(data_in), .data_valid(data_valid), .data_ready(dr1),
    .bit_out(bo1), .tx_en(te1), .state(st1), .underflow_cnt(uf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    int b;
    int te;
    int uf;
    int rdy;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_bad = 0;

  int pl[2] = '{P0, P1};
  int tl[2] = '{T0, T1};
  int ufmax[2] = '{65535, 7};
  bit act[2];
  int k[2];
  int muf[2];
  int prbs[127];

  bit cap_on = 1'b0;
  int cap[$];

  task automatic chk(string nm, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
    end
  endtask

  // Expected outputs after the coming edge, from position in the sequence.
  function automatic exp_t model(int i, bit r, bit s_in, bit sp,
                                 bit dv, bit di);
    exp_t e;
    int s;
    int b;
    s = 0;
    b = 0;
    if (r) begin
      act[i] = 1'b0;
      k[i] = 0;
      muf[i] = 0;
    end else if (!act[i]) begin
      if (s_in && !sp) begin
        act[i] = 1'b1;
        k[i] = 0;
        muf[i] = 0;
      end
    end else if (sp) begin
      act[i] = 1'b0;
    end else begin
      k[i]++;
      if (k[i] > pl[i] + tl[i]) begin
        b = dv ? int'(di) : 0;
        if (!dv && muf[i] < ufmax[i]) muf[i]++;
      end
    end
    if (act[i]) begin
      if (k[i] < pl[i]) begin
        s = 1;
        b = (k[i] % 2 == 0) ? 1 : 0;
      end else if (k[i] < pl[i] + tl[i]) begin
        s = 2;
        b = prbs[k[i] - pl[i]];
      end else begin
        s = 3;
      end
    end
    e.st = s;
    e.b = b;
    e.te = act[i] ? 1 : 0;
    e.uf = muf[i];
    e.rdy = (s == 3 && !sp) ? 1 : 0;
    return e;
  endfunction

  task automatic step(bit r, bit s_in, bit sp, bit dv, bit di);
    @(negedge clk);
    rst_n = r ? 1'b0 : 1'b1;
    start = s_in;
    stop = sp;
    data_valid = dv;
    data_in = di;
    q0.push_back(model(0, r, s_in, sp, dv, di));
    q1.push_back(model(1, r, s_in, sp, dv, di));
  endtask

  task automatic rnd_step(int p_start, int p_stop);
    bit s_in, sp, dv, di;
    s_in = ($urandom_range(p_start - 1) == 0);
    sp = (p_stop > 0) ? ($urandom_range(p_stop - 1) == 0) : 1'b0;
    dv = ($urandom_range(3) != 0);
    di = 1'($urandom());
    step(1'b0, s_in, sp, dv, di);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ".i0.state"}, int'(st0), 0);
    chk({tag, ".i0.bit"}, int'(bo0), 0);
    chk({tag, ".i0.tx_en"}, int'(te0), 0);
    chk({tag, ".i0.uf"}, int'(uf0), 0);
    chk({tag, ".i0.ready"}, int'(dr0), 0);
    chk({tag, ".i1.state"}, int'(st1), 0);
    chk({tag, ".i1.bit"}, int'(bo1), 0);
    chk({tag, ".i1.tx_en"}, int'(te1), 0);
    chk({tag, ".i1.uf"}, int'(uf1), 0);
    chk({tag, ".i1.ready"}, int'(dr1), 0);
  endtask

  // Monitor: pops one expectation per instance each cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("i0.state", int'(st0), e.st);
        chk("i0.bit", int'(bo0), e.b);
        chk("i0.tx_en", int'(te0), e.te);
        chk("i0.uf", int'(uf0), e.uf);
        chk("i0.ready", int'(dr0), e.rdy);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("i1.state", int'(st1), e.st);
        chk("i1.bit", int'(bo1), e.b);
        chk("i1.tx_en", int'(te1), e.te);
        chk("i1.uf", int'(uf1), e.uf);
        chk("i1.ready", int'(dr1), e.rdy);
      end
      if (cap_on && st0 == 2'd2 && cap.size() < 127)
        cap.push_back(int'(bo0));
    end
  end

  initial begin
    int s;
    int ones;
    int dupes;
    int w;
    bit seen[128];
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    data_in = 1'b0;
    data_valid = 1'b0;
    // PRBS7 x^7+x^6+1 from seed all-ones
    s = 7'h7F;
    for (int n = 0; n < 127; n++) begin
      prbs[n] = ((s >> 6) ^ (s >> 5)) & 1;
      s = ((s << 1) | prbs[n]) & 7'h7F;
    end
    #3;
    chk_zero("reset");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // full run to DATA on both instances
    cap_on = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (170) rnd_step(2, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cap_on = 1'b0;

    ones = 0;
    dupes = 0;
    for (int j = 0; j < 128; j++) seen[j] = 1'b0;
    chk("prbs_len", cap.size(), 127);
    if (cap.size() == 127) begin
      for (int j = 0; j < 127; j++) begin
        ones += cap[j];
        w = 0;
        for (int m = 0; m < 7; m++) w = (w << 1) | cap[(j + m) % 127];
        if (seen[w]) dupes++;
        seen[w] = 1'b1;
      end
    end
    chk("prbs_ones", ones, 64);
    chk("prbs_window_dupes", dupes, 0);

    // stop, start+stop in IDLE, restart, stop in TRAIN cycle 3 of i1
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) rnd_step(2, 0);

    // asynchronous reset between edges, mid-preamble of i0
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    data_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0;
      k[i] = 0;
      muf[i] = 0;
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // random traffic
    repeat (600) rnd_step(8, 40);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
